// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      STOP   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam logic [3:0] OPC_HLT   = 4'hF;
   localparam int         DEF_DEPTH = 4;

   // Occupancy counters must hold the value DEPTH itself, not just DEPTH-1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; head data is visible combinationally on rdata.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW   = cnt_width(DEPTH),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO may still accept a write when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC ownership, in-order variable-latency memory
// requests, instruction FIFO towards decode, redirect flush and halt detection.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 16,
   parameter int               INSTR_W  = 16,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]       HALT_OPC = OPC_HLT
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_next,
   input  logic               id_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               hlt,
   output logic [ADDR_W-1:0]  pc
);

   localparam int            CW      = cnt_width(DEPTH);
   localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);

   fetch_state_t       state;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      discard;
   logic [CW-1:0]      count;
   logic [CW-1:0]      tag_count;
   logic               q_empty;
   logic               q_full;
   logic               tag_empty;
   logic               tag_full;
   logic [ADDR_W-1:0]  tag_addr;
   logic [INSTR_W-1:0] head_instr;
   logic [ADDR_W-1:0]  head_pc;
   logic [3:0]         head_opc;
   logic               grant;
   logic               pop;
   logic               pop_halt;
   logic               redir;
   logic               rv_stale;
   logic               rv_keep;
   logic               push;
   logic               push_halt;

   assign head_opc = head_instr[INSTR_W-1 -: 4];

   // Requests are capped so every in-flight response is guaranteed a FIFO slot.
   assign imem_req  = !rst && (state == FETCH) && !redirect_valid &&
                      (({1'b0, count} + {1'b0, outstanding}) < DEPTH_V);
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;

   assign if_valid   = !q_empty && (state != HALTED);
   assign if_instr   = if_valid ? head_instr : '0;
   assign if_pc      = if_valid ? head_pc : '0;
   assign if_pc_next = if_valid ? head_pc + ADDR_W'(2) : '0;

   assign pop      = if_valid && id_ready;
   assign pop_halt = pop && (head_opc == HALT_OPC);
   // Consuming a halt wins over a same-cycle redirect.
   assign redir    = redirect_valid && (state != HALTED) && !pop_halt;

   // A response landing on the redirect edge belongs to the flushed stream.
   assign rv_stale  = imem_rvalid && ((discard != '0) || redir);
   assign rv_keep   = imem_rvalid && !rv_stale;
   assign push      = rv_keep && (state != HALTED);
   assign push_halt = push && (imem_rdata[INSTR_W-1 -: 4] == HALT_OPC);

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .pop   (rv_keep),
      .flush (redir),
      .wdata (fetch_pc),
      .rdata (tag_addr),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   sync_fifo #(.WIDTH(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_instr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .wdata ({imem_rdata, tag_addr}),
      .rdata ({head_instr, head_pc}),
      .full  (q_full),
      .empty (q_empty),
      .count (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         hlt         <= 1'b0;
         pc          <= RESET_PC;
      end else begin
         if (pop) pc <= head_pc;

         if (pop_halt) begin
            hlt   <= 1'b1;
            state <= HALTED;
         end else if (redir) begin
            state <= FETCH;
         end else if ((state == FETCH) && push_halt) begin
            state <= STOP;
         end

         if (redir) begin
            fetch_pc    <= redirect_addr & ~ADDR_W'(1);
            outstanding <= '0;
            // Everything still in flight becomes stale; this edge's response is one of them.
            discard     <= discard + outstanding - CW'(imem_rvalid);
         end else begin
            if (grant) fetch_pc <= fetch_pc + ADDR_W'(2);
            outstanding <= outstanding + CW'(grant) - CW'(rv_keep);
            if (rv_stale) discard <= discard - CW'(1);
         end
      end
   end

   a_out_max: assert property (@(posedge clk) disable iff (rst) outstanding <= CW'(DEPTH));
   a_rv_orphan: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && (outstanding == '0) && (discard == '0)));
   a_tag_track: assert property (@(posedge clk) disable iff (rst) tag_count == outstanding);
   a_tag_ovf: assert property (@(posedge clk) disable iff (rst) !(grant && tag_full));
   a_tag_udf: assert property (@(posedge clk) disable iff (rst) !(rv_keep && tag_empty));
   a_q_ovf: assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order fixed-latency memory model.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_next;
   logic        id_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_addr = 16'h0;
   logic        hlt;
   logic [15:0] pc;

   int          checks = 0;
   int          failures = 0;
   int          lat = 1;
   logic        halt_en = 1'b0;
   logic [15:0] halt_addr = 16'h0006;
   int          grant_count;
   int          cyc;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] due;
   } req_t;
   req_t q[$];

   fetch_queue_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_next     (if_pc_next),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .hlt            (hlt),
      .pc             (pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_data(input logic [15:0] a);
      if (halt_en && a == halt_addr) return 16'hF000;
      return {4'h1, a[11:0]};
   endfunction

   // Memory model: decides at the falling edge what the next rising edge sees.
   always @(negedge clk) begin
      req_t r;
      if (rst) begin
         q.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = 16'h0;
         cyc         = 0;
         grant_count = 0;
      end else begin
         cyc++;
         imem_rvalid = 1'b0;
         if (q.size() > 0 && q[0].due <= 32'(cyc)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(q[0].addr);
            void'(q.pop_front());
         end
         if (imem_req && imem_gnt) begin
            r.addr = imem_addr;
            r.due  = 32'(cyc + lat);
            q.push_back(r);
            grant_count++;
         end
      end
   end

   task automatic do_reset(input int l, input logic ir, input logic he);
      rst = 1'b1;
      lat = l;
      id_ready = ir;
      halt_en = he;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0h exp=0", if_valid); end
      checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL reset_hlt got=%0h exp=0", hlt); end
      checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
      checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
      checks++; if (if_pc_next !== 16'h0000) begin failures++; $display("FAIL reset_pc_next got=%0h exp=0", if_pc_next); end
   endtask

   task automatic test_stream();
      logic [15:0] exp;
      do_reset(1, 1'b1, 1'b0);
      for (int i = 0; i < 10 && !if_valid; i++) cycles(1);
      for (int i = 0; i < 5; i++) begin
         exp = 16'(2 * i);
         checks++; if (if_valid !== 1'b1 || if_pc !== exp) begin failures++; $display("FAIL stream_pc got=%0h/%0h exp=1/%0h", if_valid, if_pc, exp); end
         checks++; if (if_instr !== (16'h1000 | exp)) begin failures++; $display("FAIL stream_instr got=%0h exp=%0h", if_instr, 16'h1000 | exp); end
         checks++; if (if_pc_next !== exp + 16'd2) begin failures++; $display("FAIL stream_pc_next got=%0h exp=%0h", if_pc_next, exp + 16'd2); end
         cycles(1);
      end
      checks++; if (pc !== 16'h0008) begin failures++; $display("FAIL stream_arch_pc got=%0h exp=8", pc); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp;
      int pops;
      do_reset(1, 1'b0, 1'b0);
      cycles(12);
      checks++; if (grant_count != 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", grant_count); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%0h exp=0", imem_req); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0) begin failures++; $display("FAIL bp_head got=%0h/%0h exp=1/0", if_valid, if_pc); end
      id_ready = 1'b1;
      exp = 16'h0;
      pops = 0;
      for (int i = 0; i < 12; i++) begin
         if (if_valid) begin
            checks++; if (if_pc !== exp) begin failures++; $display("FAIL bp_order got=%0h exp=%0h", if_pc, exp); end
            exp = exp + 16'd2;
            pops++;
         end
         cycles(1);
      end
      checks++; if (pops != 12) begin failures++; $display("FAIL bp_pops got=%0d exp=12", pops); end
      checks++; if (grant_count != 15) begin failures++; $display("FAIL bp_refill_grants got=%0d exp=15", grant_count); end
   endtask

   task automatic test_redirect();
      do_reset(3, 1'b1, 1'b0);
      for (int i = 0; i < 10 && grant_count < 3; i++) cycles(1);
      checks++; if (grant_count != 3) begin failures++; $display("FAIL redir_inflight got=%0d exp=3", grant_count); end
      redirect_valid = 1'b1;
      redirect_addr = 16'h0101;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req_block got=%0h exp=0", imem_req); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL redir_addr got=%0h/%0h exp=1/100", imem_req, imem_addr); end
      for (int i = 0; i < 12 && !if_valid; i++) cycles(1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100) begin failures++; $display("FAIL redir_first_pc got=%0h/%0h exp=1/100", if_valid, if_pc); end
      checks++; if (if_instr !== 16'h1100) begin failures++; $display("FAIL redir_first_instr got=%0h exp=1100", if_instr); end
      cycles(1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0102) begin failures++; $display("FAIL redir_second_pc got=%0h/%0h exp=1/102", if_valid, if_pc); end
   endtask

   task automatic test_halt();
      do_reset(1, 1'b0, 1'b1);
      cycles(8);
      checks++; if (imem_req !== 1'b0 || grant_count != 4) begin failures++; $display("FAIL halt_stop got=%0h/%0d exp=0/4", imem_req, grant_count); end
      id_ready = 1'b1;
      cycles(3);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0006) begin failures++; $display("FAIL halt_head got=%0h/%0h exp=1/6", if_valid, if_pc); end
      checks++; if (if_instr !== 16'hF000) begin failures++; $display("FAIL halt_instr got=%0h exp=f000", if_instr); end
      checks++; if (hlt !== 1'b0 || pc !== 16'h0004) begin failures++; $display("FAIL halt_pre got=%0h/%0h exp=0/4", hlt, pc); end
      checks++; if (grant_count != 4) begin failures++; $display("FAIL halt_no_issue got=%0d exp=4", grant_count); end
      cycles(1);
      checks++; if (hlt !== 1'b1 || pc !== 16'h0006) begin failures++; $display("FAIL halt_post got=%0h/%0h exp=1/6", hlt, pc); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_if_valid got=%0h exp=0", if_valid); end
      redirect_valid = 1'b1;
      redirect_addr = 16'h0040;
      cycles(2);
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0008) begin failures++; $display("FAIL halt_redir_ignored got=%0h/%0h exp=0/8", imem_req, imem_addr); end
      checks++; if (hlt !== 1'b1 || pc !== 16'h0006 || if_valid !== 1'b0) begin failures++; $display("FAIL halt_sticky got=%0h/%0h/%0h exp=1/6/0", hlt, pc, if_valid); end
   endtask

   task automatic test_halt_flush();
      do_reset(1, 1'b0, 1'b1);
      cycles(8);
      redirect_valid = 1'b1;
      redirect_addr = 16'h0020;
      cycles(1);
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL hflush_addr got=%0h/%0h exp=1/20", imem_req, imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL hflush_cleared got=%0h exp=0", if_valid); end
      id_ready = 1'b1;
      for (int i = 0; i < 10 && !if_valid; i++) cycles(1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0020 || if_instr !== 16'h1020) begin failures++; $display("FAIL hflush_first got=%0h/%0h/%0h exp=1/20/1020", if_valid, if_pc, if_instr); end
      cycles(6);
      checks++; if (hlt !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h002C) begin failures++; $display("FAIL hflush_resume got=%0h/%0h/%0h exp=0/1/2c", hlt, if_valid, if_pc); end
   endtask

   task automatic test_wrap_reset();
      do_reset(1, 1'b1, 1'b0);
      cycles(3);
      redirect_valid = 1'b1;
      redirect_addr = 16'hFFFF;
      cycles(1);
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_start got=%0h/%0h exp=1/fffe", imem_req, imem_addr); end
      cycles(1);
      checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%0h exp=0", imem_addr); end
      for (int i = 0; i < 10 && !if_valid; i++) cycles(1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFE || if_instr !== 16'h1FFE) begin failures++; $display("FAIL wrap_head got=%0h/%0h/%0h exp=1/fffe/1ffe", if_valid, if_pc, if_instr); end
      checks++; if (if_pc_next !== 16'h0000) begin failures++; $display("FAIL wrap_pc_next got=%0h exp=0", if_pc_next); end
      cycles(1);
      checks++; if (if_pc !== 16'h0000 || pc !== 16'hFFFE) begin failures++; $display("FAIL wrap_next got=%0h/%0h exp=0/fffe", if_pc, pc); end
      #2 rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out got=%0h/%0h exp=0/0", imem_req, if_valid); end
      checks++; if (pc !== 16'h0000 || hlt !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL async_rst_state got=%0h/%0h/%0h exp=0/0/0", pc, hlt, imem_addr); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10 && !if_valid; i++) cycles(1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1000) begin failures++; $display("FAIL rst_restart got=%0h/%0h/%0h exp=1/0/1000", if_valid, if_pc, if_instr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_halt_flush();
      test_wrap_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core. Replaces the single-cycle PC register plus always-ready instruction memory read.
- Owns the PC and issues in-order requests to a variable-latency instruction memory. Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirect (flush), stale-response discard and halt detection.

Parameters:
- ADDR_W, 16: PC and memory address width (byte address, 2-byte aligned).
- INSTR_W, 16: instruction width.
- DEPTH, 4: FIFO entries and maximum in-flight requests plus buffered instructions; power of 2, at least 2.
- RESET_PC, 0: PC value after reset.
- HALT_OPC, 4'hF: opcode, instr[INSTR_W-1:INSTR_W-4], that marks HLT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address; bit 0 always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  INSTR_W  response data.
- if_valid  out  1  FIFO head valid.
- if_instr  out  INSTR_W  head instruction.
- if_pc  out  ADDR_W  head instruction address.
- if_pc_next  out  ADDR_W  if_pc + 2, used by PCS.
- id_ready  in  1  decode consumes the head when if_valid && id_ready.
- redirect_valid  in  1  branch taken or branch-register: flush and refetch.
- redirect_addr  in  ADDR_W  new PC; bit 0 ignored (forced 0).
- hlt  out  1  a halt instruction has been consumed; sticky.
- pc  out  ADDR_W  address of the last consumed instruction (architectural PC).

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=FETCH. Reset values: imem_req=0, if_valid=0, hlt=0, pc=RESET_PC; other outputs 0. Reset mid-transaction abandons all in-flight requests; late responses are the memory's responsibility to suppress on rst.
- imem_req = (state==FETCH) && (count + outstanding < DEPTH) && !redirect_valid. imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 2 (wraps modulo 2^ADDR_W); outstanding += 1. Each request records its address in an address-tag FIFO written at grant time.
- On imem_rvalid:
  - If discard>0: discard -= 1 and drop the data.
  - Otherwise write {data, tag addr} into the FIFO; outstanding -= 1.
- Grant and response in the same cycle: both counter effects apply (net 0).
- Pop when if_valid && id_ready: count -= 1; pc <= popped if_pc. If the popped opcode == HALT_OPC: state -> HALTED and hlt=1 from the next cycle.
- Push and pop in the same cycle are both allowed when full or empty. When empty there is no combinational bypass: write-to-if_valid latency is 1 cycle.
- In FETCH, a pushed instruction whose opcode == HALT_OPC moves state to STOP. Issue stops; already-granted requests are kept.
- redirect_valid, in FETCH or STOP:
  - Same edge: FIFO cleared, discard <= outstanding (minus one if a response is arriving this cycle), outstanding <= 0, fetch_pc <= redirect_addr & ~1, state <= FETCH.
  - A simultaneous pop still completes and updates pc/hlt, and halt takes priority over the redirect.
  - Simultaneous rvalid is treated as stale.
- HALTED: terminal until reset. imem_req=0, if_valid=0, redirect ignored, responses still drain the counters.
- Full: when count+outstanding==DEPTH there is no request; if_valid is held.
- Counters are clog2(DEPTH+1) bits. Assertions: outstanding never exceeds DEPTH; rvalid never arrives with outstanding+discard==0.

Decomposition:
- Package fetch_pkg: state enum {FETCH, STOP, HALTED}, OPC_HLT constant, localparam CNT_W = clog2(DEPTH+1).
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, count). Instantiated twice: instruction+PC FIFO and in-flight address-tag FIFO.

Test Plan:
- Zero-wait memory (gnt=1, rvalid 1 cycle later), id_ready=1 -> instructions at 0x0000, 0x0002, 0x0004… appear on consecutive cycles; if_pc_next = if_pc+2.
- id_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0. Raise id_ready -> one new request per pop, and no instruction is lost or duplicated.
- 3-cycle response latency, 3 requests in flight, redirect_valid to 0x0101 -> the 3 stale responses are dropped, the next request address is 0x0100, and the first if_instr comes from 0x0100.
- Instruction 16'hF000 at 0x0006 -> state STOP and no further requests. On its pop, hlt=1 next cycle and pc=0x0006. A redirect afterwards is ignored.
- Halt pushed into the FIFO, then redirect to 0x0020 before the halt is consumed -> halt flushed, fetching resumes at 0x0020, hlt stays 0.
- fetch_pc=0xFFFE with grant -> next imem_addr=0x0000. rst asserted mid-flight -> outputs at reset values immediately (asynchronously); fetch restarts at RESET_PC after release.
